muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide execute unit. Consumes the two register-file read operands
//  (rs1/rs2 values) alongside the ALU, runs a fixed-latency shift-add / restoring-divide

---
 rtl/muldiv_unit.sv | 183 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M multiply/divide execute unit. Operands are captured at
//   start. The unit then runs a fixed DATA_WIDTH-step sequence: shift-add
//   multiply or restoring divide, on operand magnitudes. It applies the
//   result sign at the end. It presents the result for one cycle together
//   with the destination register and the register-file write enable.
//   Only one operation can be in flight. Upstream stalls while busy is high.
//
// Ports
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   start   in   operation request, sampled only while idle
//   funct3  in   000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//                100 DIV, 101 DIVU, 110 REM,    111 REMU
//   op1     in   rs1 value
//   op2     in   rs2 value
//   rd_in   in   destination register index
//   flush   in   abort the in-flight operation without writeback
//   busy    out  high from acceptance through the result cycle
//   done    out  one-cycle result-valid pulse
//   result  out  result, valid while done
//   rd_out  out  destination register, valid while done
//   wr_en   out  done && rd_out != 0
// ---------------------------------------------------------------------------
module muldiv_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_DATA_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [2:0]                funct3,
  input  logic [DATA_WIDTH-1:0]     op1,
  input  logic [DATA_WIDTH-1:0]     op2,
  input  logic [REG_DATA_WIDTH-1:0] rd_in,
  input  logic                      flush,
  output logic                      busy,
  output logic                      done,
  output logic [DATA_WIDTH-1:0]     result,
  output logic [REG_DATA_WIDTH-1:0] rd_out,
  output logic                      wr_en
);

  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]             count;
  logic [2:0]                op_q;
  logic [REG_DATA_WIDTH-1:0] rd_q;
  logic                      negate_q;
  logic                      div_zero_q;
  // Multiply: acc_hi = running upper product, acc_lo = multiplier bits
  // shifting out as product bits shift in. Divide: acc_hi = partial
  // remainder, acc_lo = dividend bits shifting out as quotient bits shift in.
  logic [DATA_WIDTH-1:0]     acc_hi;
  logic [DATA_WIDTH-1:0]     acc_lo;
  logic [DATA_WIDTH-1:0]     operand_b;

  // Operand decode at acceptance.
  logic                  is_div;
  logic                  op1_signed, op2_signed;
  logic                  op1_neg, op2_neg;
  logic [DATA_WIDTH-1:0] mag1, mag2;
  logic                  negate_start;

  always_comb begin
    is_div       = funct3[2];
    op1_signed   = is_div ? ~funct3[0] : (funct3 != 3'b011);
    op2_signed   = is_div ? ~funct3[0] : ~funct3[1];
    op1_neg      = op1_signed & op1[DATA_WIDTH-1];
    op2_neg      = op2_signed & op2[DATA_WIDTH-1];
    mag1         = op1_neg ? -op1 : op1;
    mag2         = op2_neg ? -op2 : op2;
    // The remainder takes the dividend's sign. Everything else takes the xor of both signs.
    negate_start = (is_div && funct3[1]) ? op1_neg : (op1_neg ^ op2_neg);
  end

  // One iteration of each algorithm. Both are evaluated every cycle, and
  // the latched operation picks which one is committed.
  logic [DATA_WIDTH:0]   mul_sum;
  logic [DATA_WIDTH:0]   div_shift;
  logic [DATA_WIDTH:0]   div_diff;
  logic [DATA_WIDTH-1:0] hi_step, lo_step;

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand_b} : '0);
    div_shift = {acc_hi, acc_lo[DATA_WIDTH-1]};
    div_diff  = div_shift - {1'b0, operand_b};
    if (op_q[2]) begin
      // A set top bit means the trial subtraction borrowed, so restore.
      if (div_diff[DATA_WIDTH]) begin
        hi_step = div_shift[DATA_WIDTH-1:0];
        lo_step = {acc_lo[DATA_WIDTH-2:0], 1'b0};
      end else begin
        hi_step = div_diff[DATA_WIDTH-1:0];
        lo_step = {acc_lo[DATA_WIDTH-2:0], 1'b1};
      end
    end else begin
      hi_step = mul_sum[DATA_WIDTH:1];
      lo_step = {mul_sum[0], acc_lo[DATA_WIDTH-1:1]};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic. Flush overrides every other transition.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = BUSY;
      BUSY:    if (count == CW'(DATA_WIDTH - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // Datapath registers: operands are captured on acceptance and then
  // advanced one step per BUSY cycle. Later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      negate_q   <= 1'b0;
      div_zero_q <= 1'b0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      operand_b  <= '0;
    end else if (!flush) begin
      if (state == IDLE && start) begin
        count      <= '0;
        op_q       <= funct3;
        rd_q       <= rd_in;
        negate_q   <= negate_start;
        div_zero_q <= (op2 == '0);
        acc_hi     <= '0;
        acc_lo     <= is_div ? mag1 : mag2;
        operand_b  <= is_div ? mag2 : mag1;
      end else if (state == BUSY) begin
        count  <= count + 1'b1;
        acc_hi <= hi_step;
        acc_lo <= lo_step;
      end
    end
  end

  // Result formation. Division by zero is the one case that the sign fixup
  // does not produce: the quotient is forced to all ones. The remainder
  // naturally ends up equal to op1.
  logic [2*DATA_WIDTH-1:0] product;
  logic [DATA_WIDTH-1:0]   mul_res, quo_res, rem_res, final_res;

  always_comb begin
    product   = negate_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    mul_res   = (op_q[1:0] == 2'b00) ? product[DATA_WIDTH-1:0]
                                     : product[2*DATA_WIDTH-1:DATA_WIDTH];
    quo_res   = div_zero_q ? '1 : (negate_q ? -acc_lo : acc_lo);
    rem_res   = negate_q ? -acc_hi : acc_hi;
    final_res = op_q[2] ? (op_q[1] ? rem_res : quo_res) : mul_res;
  end

  always_comb begin
    busy   = (state != IDLE);
    done   = (state == DONE);
    result = done ? final_res : '0;
    rd_out = done ? rd_q : '0;
    wr_en  = done && (rd_q != '0);
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
//   Directed-vector bench for muldiv_unit. Each vector has a hand-computed
//   expected result, latency and destination.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [4:0]  rd_in;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        wr_en;

  int vector_count = 0;
  int miss_count   = 0;

  muldiv_unit #(.DATA_WIDTH(32), .REG_DATA_WIDTH(5)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .funct3 (funct3),
    .op1    (op1),
    .op2    (op2),
    .rd_in  (rd_in),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rd_out (rd_out),
    .wr_en  (wr_en)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vector_count++;
    if (observed !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Advances one full cycle and returns at the following negedge.
  task automatic stepCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge in IDLE. The caller returns at the negedge after
  // acceptance, and the inputs are then scrambled to show they are not reused.
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd);
    funct3 = f3;
    op1    = a;
    op2    = b;
    rd_in  = rd;
    start  = 1'b1;
    stepCycle();
    start  = 1'b0;
    op1    = $urandom;
    op2    = $urandom;
    funct3 = 3'($urandom_range(0, 7));
    rd_in  = 5'($urandom_range(0, 31));
  endtask

  // Waits (bounded) for done, then checks latency, result and writeback
  // fields. Returns at the negedge of the following IDLE cycle.
  task automatic waitResult(input string tag, input int exp_latency,
                            input logic [31:0] exp_result, input logic [4:0] exp_rd);
    int n = 0;
    bit seen = 1'b0;
    while (n < 100 && !seen) begin
      stepCycle();
      n++;
      if (done === 1'b1) seen = 1'b1;
    end
    checkOutput({tag, ".latency"}, 32'(n), 32'(exp_latency));
    if (seen) begin
      checkOutput({tag, ".result"}, result, exp_result);
      checkOutput({tag, ".rd_out"}, 32'(rd_out), 32'(exp_rd));
      checkOutput({tag, ".wr_en"},  32'(wr_en),  32'(exp_rd != 5'd0));
      checkOutput({tag, ".busy"},   32'(busy),   32'd1);
      stepCycle();
      checkOutput({tag, ".done_low"}, 32'(done), 32'd0);
    end
  endtask

  initial begin
    int seen_done;
    rst_n  = 1'b0;
    start  = 1'b0;
    flush  = 1'b0;
    funct3 = 3'b000;
    op1    = '0;
    op2    = '0;
    rd_in  = '0;

    #1;
    checkOutput("reset.busy",   32'(busy),   32'd0);
    checkOutput("reset.done",   32'(done),   32'd0);
    checkOutput("reset.result", result,      32'd0);
    checkOutput("reset.rd_out", 32'(rd_out), 32'd0);
    checkOutput("reset.wr_en",  32'(wr_en),  32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Multiply family.
    applyStimulus(F_MUL, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5);
    waitResult("mul_7x-3", 32, 32'hFFFF_FFEB, 5'd5);
    applyStimulus(F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6);
    waitResult("mulhu_ff", 32, 32'hFFFF_FFFE, 5'd6);
    applyStimulus(F_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
    waitResult("mulh_ff", 32, 32'h0000_0000, 5'd7);
    applyStimulus(F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8);
    waitResult("mulhsu_ff", 32, 32'hFFFF_FFFF, 5'd8);
    applyStimulus(F_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9);
    waitResult("mul_ff", 32, 32'h0000_0001, 5'd9);
    applyStimulus(F_MUL, 32'h1234_5678, 32'h0000_0009, 5'd31);
    waitResult("mul_x9", 32, 32'hA3D7_0A38, 5'd31);

    // Divide family.
    applyStimulus(F_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 5'd10);
    waitResult("div_-7/2", 32, 32'hFFFF_FFFD, 5'd10);
    applyStimulus(F_REM, 32'hFFFF_FFF9, 32'h0000_0002, 5'd11);
    waitResult("rem_-7/2", 32, 32'hFFFF_FFFF, 5'd11);
    applyStimulus(F_DIVU, 32'd100, 32'd7, 5'd12);
    waitResult("divu_100/7", 32, 32'd14, 5'd12);
    applyStimulus(F_REMU, 32'd100, 32'd7, 5'd13);
    waitResult("remu_100/7", 32, 32'd2, 5'd13);
    applyStimulus(F_DIV, 32'h0000_0007, 32'hFFFF_FFFE, 5'd14);
    waitResult("div_7/-2", 32, 32'hFFFF_FFFD, 5'd14);
    applyStimulus(F_REM, 32'h0000_0007, 32'hFFFF_FFFE, 5'd15);
    waitResult("rem_7/-2", 32, 32'h0000_0001, 5'd15);

    // Division by zero and signed overflow.
    applyStimulus(F_DIV, 32'd5, 32'd0, 5'd16);
    waitResult("div_5/0", 32, 32'hFFFF_FFFF, 5'd16);
    applyStimulus(F_REM, 32'd5, 32'd0, 5'd17);
    waitResult("rem_5/0", 32, 32'd5, 5'd17);
    applyStimulus(F_REM, 32'hFFFF_FFF9, 32'd0, 5'd18);
    waitResult("rem_-7/0", 32, 32'hFFFF_FFF9, 5'd18);
    applyStimulus(F_DIVU, 32'hFFFF_FFF9, 32'd0, 5'd19);
    waitResult("divu_x/0", 32, 32'hFFFF_FFFF, 5'd19);
    applyStimulus(F_REMU, 32'h8000_0000, 32'd0, 5'd20);
    waitResult("remu_x/0", 32, 32'h8000_0000, 5'd20);
    applyStimulus(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd21);
    waitResult("div_ovf", 32, 32'h8000_0000, 5'd21);
    applyStimulus(F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd22);
    waitResult("rem_ovf", 32, 32'h0000_0000, 5'd22);

    // A second start while busy is ignored and does not restart the sequence.
    applyStimulus(F_MUL, 32'd6, 32'd7, 5'd3);
    repeat (5) stepCycle();
    funct3 = F_DIV;
    op1    = 32'd100;
    op2    = 32'd100;
    rd_in  = 5'd4;
    start  = 1'b1;
    stepCycle();
    start  = 1'b0;
    waitResult("start_ignored", 26, 32'd42, 5'd3);

    // A flush in mid-sequence aborts the operation with no done pulse.
    applyStimulus(F_DIV, 32'd1000, 32'd3, 5'd9);
    repeat (9) stepCycle();
    flush = 1'b1;
    stepCycle();
    flush = 1'b0;
    checkOutput("flush.busy", 32'(busy), 32'd0);
    seen_done = 0;
    repeat (40) begin
      stepCycle();
      if (done === 1'b1) seen_done++;
    end
    checkOutput("flush.no_done", 32'(seen_done), 32'd0);
    applyStimulus(F_DIVU, 32'd1000, 32'd3, 5'd9);
    waitResult("after_flush", 32, 32'd333, 5'd9);

    // Asynchronous reset while busy clears the outputs without waiting for a clock edge.
    applyStimulus(F_MUL, 32'd3, 32'd5, 5'd7);
    repeat (3) stepCycle();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid.busy",   32'(busy),   32'd0);
    checkOutput("rst_mid.done",   32'(done),   32'd0);
    checkOutput("rst_mid.result", result,      32'd0);
    checkOutput("rst_mid.rd_out", 32'(rd_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid.idle", 32'(busy), 32'd0);

    // A destination of x0 still completes but never writes.
    applyStimulus(F_MUL, 32'd3, 32'd4, 5'd0);
    waitResult("mul_rd0", 32, 32'd12, 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
    $finish;
  end

endmodule
